// File: rtl/cpu_btn_debounce.sv
// Pushbutton conditioner: synchroniser, polarity normalisation, 4-state debounce FSM, press/release strobes.
// Optional long-press strobe enabled by defining BTN_LONG_PRESS_EN.
module cpu_btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
`ifdef BTN_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_WIDTH      = 27,
  parameter int unsigned LONG_CYCLES     = 100000000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic out_port,
  output logic press_pulse,
  output logic release_pulse
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam logic RELEASED_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 press_nxt, release_nxt;
  logic                 s;

  assign s = sync[SYNC_STAGES-1] ^ RELEASED_LEVEL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= {SYNC_STAGES{RELEASED_LEVEL}};
      state         <= IDLE;
      cnt           <= '0;
      out_port      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], btn_raw};
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      out_port      <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TERM) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == TERM) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_MAX = LONG_WIDTH'(LONG_CYCLES);

  logic [LONG_WIDTH-1:0] long_cnt, long_cnt_nxt;
  logic                  long_nxt;

  // Cleared while approaching a press so it starts at 0 on the edge out_port rises;
  // a release bounce back into PRESSED keeps the accumulated dwell.
  always_comb begin
    long_cnt_nxt = long_cnt;
    long_nxt     = 1'b0;
    case (state)
      IDLE, PRESS_WAIT: long_cnt_nxt = '0;
      PRESSED: begin
        if (long_cnt != LONG_MAX) begin
          long_cnt_nxt = long_cnt + LONG_WIDTH'(1);
          long_nxt     = (long_cnt == LONG_MAX - LONG_WIDTH'(1));
        end
      end
      default: long_cnt_nxt = long_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_cnt   <= long_cnt_nxt;
      long_press <= long_nxt;
    end
  end
`endif

endmodule
